byte_word_packer: RTL and testbench
===================================

// Module: byte_word_packer
// PURPOSE
//  Upstream feeder for the 32-bit enable-loaded data register. Packs a stream
//  of bytes (valid/ready handshake) into 32-bit words. Presents each completed
//  word on Word_out with a Word_valid strobe that drives the register's En
//  input. Holds a finished word until the consumer accepts it (backpressure).
// PARAMETERS
//  WORD_W     32  output word width; must be an integer multiple of BYTE_W
//  BYTE_W     8   input byte width
//  LSB_FIRST  1   1: first byte lands in [BYTE_W-1:0]; 0: first byte in [WORD_W-1:WORD_W-BYTE_W]
// PORTS
//  Clock       in   1       rising-edge clock
//  Reset       in   1       asynchronous, active-low reset
//  Byte_in     in   BYTE_W  input byte
//  Byte_valid  in   1       Byte_in is valid this cycle
//  Byte_ready  out  1       packer accepts a byte this cycle (comb.)
//  Flush       in   1       discard a partially assembled word
//  Word_out    out  WORD_W  assembled word (registered)
//  Word_valid  out  1       Word_out holds a complete word (registered); drives En downstream
//  Word_ready  in   1       consumer takes Word_out this cycle
//  Byte_count  out  clog2(WORD_W/BYTE_W)  bytes held in the partial word (registered)
// BEHAVIOUR
//  Reset (Reset=0, async): state=COLLECT, Byte_count=0, Word_out=0,
//   Word_valid=0, internal shift buffer=0. Takes effect immediately, mid-word included.
//  Byte accept = Byte_valid & Byte_ready. Word handoff = Word_valid & Word_ready.
//  Byte_ready = !Flush & (state==COLLECT | (state==FULL & Word_ready)).
//  COLLECT: on accept, write byte into lane Byte_count (lane order per LSB_FIRST) and increment Byte_count.
//   Last lane (Byte_count==N-1) accepted: copy full buffer to Word_out,
//   set Word_valid=1, Byte_count=0 -> FULL. Latency: word visible the cycle after the final byte edge.
//  FULL: Word_out and Word_valid are stable until handoff.
//   Handoff, no accept: Word_valid=0 -> COLLECT.
//   Handoff and accept same cycle: Word_valid=0, byte stored as lane 0, Byte_count=1 -> COLLECT.
//   Byte_valid without Word_ready: Byte_ready=0, byte not taken; producer holds it.
//  Flush: in COLLECT, Byte_count=0 and buffer cleared next edge.
//   Byte_ready=0 while Flush=1, so no byte is taken that cycle.
//   In FULL, Flush does not affect the held word or handoff.
//  Word_out keeps its last value after handoff; only a completed word or reset changes it.
//  Byte_count wraps N-1 -> 0 only on word completion. There is no other wrap.
//  Byte_valid=0 on any cycle: no state change (gaps are legal anywhere).
// STRUCTURE
//  Shared package: state enum {COLLECT, FULL}.
//   Also: constant BYTES_PER_WORD = WORD_W/BYTE_W and its count width.
//  Single module: FSM, lane-indexed byte buffer, output word register.
//   No sub-module is needed.
//  Top-level wiring: Word_out -> Data_in, Word_valid -> En, shared Clock/Reset.
// TESTING
//  1 Reset=0 mid-word (Byte_count=2) -> Byte_count=0, Word_valid=0, Word_out=0 immediately.
//  2 LSB_FIRST=1, bytes 11,22,33,44 back-to-back, Word_ready=1.
//    -> Word_out=32'h44332211, Word_valid=1 for one cycle, one edge after byte 44.
//  3 LSB_FIRST=0, same bytes -> Word_out=32'h11223344.
//  4 Word_ready=0 after word AABBCCDD, Byte_valid=1 with byte 55.
//    -> Byte_ready=0, word held 3 cycles.
//    -> raise Word_ready: word handed off and 55 taken same edge, Byte_count=1.
//  5 bytes 01,02 then Flush=1 with Byte_valid=1 -> Byte_ready=0, Byte_count=0.
//    -> then 0A,0B,0C,0D gives Word_out=32'h0D0C0B0A.
//  6 Random gaps in Byte_valid, 8 words, via downstream register.
//    -> register Data_out matches scoreboard word order; no byte lost or duplicated.

Source files
------------

// File: rtl/byte_word_packer_pkg.sv
// ============================================================================
// Package     : byte_word_packer_pkg
// Description : Shared types and constants for the byte-to-word packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package byte_word_packer_pkg;

  // Packer FSM: gathering bytes, or holding a finished word for the consumer
  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  // Default geometry: 32-bit words built from 8-bit bytes
  localparam int BYTES_PER_WORD = 32 / 8;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  // Width of a counter indexing n lanes; never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : byte_word_packer_pkg

`default_nettype wire

// File: rtl/byte_word_packer.sv
// ============================================================================
// Module      : byte_word_packer
// Description : Packs a valid/ready byte stream into WORD_W-bit words and
//               presents each completed word with a registered valid strobe,
//               holding it until the consumer accepts it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_word_packer
  import byte_word_packer_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int BYTE_W    = 8,
  parameter int LSB_FIRST = 1,
  localparam int N        = WORD_W / BYTE_W,
  localparam int CNT_W    = cnt_width(N)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  input  logic              flush_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic [CNT_W-1:0]  byte_count_o
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  buf_q, buf_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               valid_q, valid_d;

  logic               w_accept;
  logic [CNT_W-1:0]   w_lane;
  logic [WORD_W-1:0]  w_merged;

  // A byte may enter while collecting, or while full if the held word leaves on the same edge
  assign byte_ready_o = !flush_i && ((state_q == COLLECT) || ((state_q == FULL) && word_ready_i));
  assign w_accept     = byte_valid_i && byte_ready_o;

  // Logical lane number maps to a physical lane according to byte order
  assign w_lane = (LSB_FIRST != 0) ? cnt_q : (C_LAST - cnt_q);

  // Buffer contents with the incoming byte dropped into its lane
  always_comb begin
    w_merged = buf_q;
    w_merged[w_lane*BYTE_W +: BYTE_W] = byte_i;
  end

  // Next-state logic for FSM, lane counter, buffer and output word
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    word_d  = word_q;
    valid_d = valid_q;
    unique case (state_q)
      COLLECT: begin
        if (flush_i) begin
          cnt_d = '0;
          buf_d = '0;
        end else if (w_accept) begin
          if (cnt_q == C_LAST) begin
            // Final lane: publish the word and start the next one empty
            word_d  = w_merged;
            valid_d = 1'b1;
            cnt_d   = '0;
            buf_d   = '0;
            state_d = FULL;
          end else begin
            buf_d = w_merged;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FULL: begin
        // Counter is zero here, so w_merged already places the byte in lane 0
        if (word_ready_i) begin
          valid_d = 1'b0;
          state_d = COLLECT;
          if (w_accept) begin
            buf_d = w_merged;
            cnt_d = CNT_W'(1);
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      buf_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  assign byte_count_o = cnt_q;

endmodule : byte_word_packer

`default_nettype wire

// File: tb/tb_byte_word_packer.sv
// ============================================================================
// Module      : tb_byte_word_packer
// Description : Directed self-checking bench for byte_word_packer, covering
//               both byte orders, backpressure, flush, async reset and a
//               gapped stream into a downstream enable register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_byte_word_packer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        flush;
  logic        word_ready;

  logic        ready_l, ready_m;
  logic        wv_l, wv_m;
  logic [31:0] word_l, word_m;
  logic [1:0]  cnt_l, cnt_m;

  logic [31:0] dreg;

  int compared   = 0;
  int mismatched = 0;

  byte_word_packer #(.WORD_W(32), .BYTE_W(8), .LSB_FIRST(1)) u_lsb (
    .clk_i(clk), .rst_ni(rst_n), .byte_i(byte_in), .byte_valid_i(byte_valid),
    .byte_ready_o(ready_l), .flush_i(flush), .word_o(word_l),
    .word_valid_o(wv_l), .word_ready_i(word_ready), .byte_count_o(cnt_l)
  );

  byte_word_packer #(.WORD_W(32), .BYTE_W(8), .LSB_FIRST(0)) u_msb (
    .clk_i(clk), .rst_ni(rst_n), .byte_i(byte_in), .byte_valid_i(byte_valid),
    .byte_ready_o(ready_m), .flush_i(flush), .word_o(word_m),
    .word_valid_o(wv_m), .word_ready_i(word_ready), .byte_count_o(cnt_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 32-bit enable-loaded register fed by the LSB-first packer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    dreg <= '0;
    else if (wv_l) dreg <= word_l;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Gapped-stream scoreboard: compare the register after each handoff edge
  logic [31:0] exp_words [8];
  int          got  = 0;
  logic        pend = 1'b0;
  logic        mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (pend) begin
        if (got < 8) chk($sformatf("stream_word%0d", got), dreg, exp_words[got]);
        else         chk("stream_extra_word", 32'd1, 32'd0);
        got++;
      end
      pend = wv_l && word_ready;
    end
  end

  typedef struct {
    logic        v;
    logic [7:0]  b;
    logic        f;
    logic        wr;
    logic        exp_rdy;
    logic        exp_wv;
    logic [31:0] exp_wl;
    logic [31:0] exp_wm;
    logic [1:0]  exp_cnt;
  } vec_t;

  vec_t vecs [14];

  // One cycle: drive, check combinational ready, clock, check registered outputs
  task automatic step(input logic v, input logic [7:0] b, input logic f, input logic wr);
    byte_valid = v;
    byte_in    = b;
    flush      = f;
    word_ready = wr;
    #1;
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sbytes [32];
  int         idx;
  int         cyc;

  initial begin
    rst_n = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Vector table: tests 2, 3 and 5 plus an idle gap
    vecs[0]  = '{1, 8'h11, 0, 1, 1, 0, 32'h0,        32'h0,        2'd1};
    vecs[1]  = '{1, 8'h22, 0, 1, 1, 0, 32'h0,        32'h0,        2'd2};
    vecs[2]  = '{1, 8'h33, 0, 1, 1, 0, 32'h0,        32'h0,        2'd3};
    vecs[3]  = '{1, 8'h44, 0, 1, 1, 1, 32'h44332211, 32'h11223344, 2'd0};
    vecs[4]  = '{0, 8'h00, 0, 1, 1, 0, 32'h44332211, 32'h11223344, 2'd0};
    vecs[5]  = '{1, 8'h01, 0, 1, 1, 0, 32'h44332211, 32'h11223344, 2'd1};
    vecs[6]  = '{1, 8'h02, 0, 1, 1, 0, 32'h44332211, 32'h11223344, 2'd2};
    vecs[7]  = '{1, 8'hFF, 1, 1, 0, 0, 32'h44332211, 32'h11223344, 2'd0};
    vecs[8]  = '{1, 8'h0A, 0, 1, 1, 0, 32'h44332211, 32'h11223344, 2'd1};
    vecs[9]  = '{1, 8'h0B, 0, 1, 1, 0, 32'h44332211, 32'h11223344, 2'd2};
    vecs[10] = '{1, 8'h0C, 0, 1, 1, 0, 32'h44332211, 32'h11223344, 2'd3};
    vecs[11] = '{1, 8'h0D, 0, 1, 1, 1, 32'h0D0C0B0A, 32'h0A0B0C0D, 2'd0};
    vecs[12] = '{0, 8'h00, 0, 1, 1, 0, 32'h0D0C0B0A, 32'h0A0B0C0D, 2'd0};
    vecs[13] = '{0, 8'h5A, 0, 0, 1, 0, 32'h0D0C0B0A, 32'h0A0B0C0D, 2'd0};

    // Reset state
    chk("rst_word", word_l, 32'h0);
    chk("rst_valid", {31'd0, wv_l}, 32'd0);
    chk("rst_count", {30'd0, cnt_l}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].v, vecs[i].b, vecs[i].f, vecs[i].wr);
      chk($sformatf("v%0d_ready", i), {31'd0, ready_l}, {31'd0, vecs[i].exp_rdy});
      post_edge();
      chk($sformatf("v%0d_valid", i),   {31'd0, wv_l},  {31'd0, vecs[i].exp_wv});
      chk($sformatf("v%0d_word_lsb", i), word_l,        vecs[i].exp_wl);
      chk($sformatf("v%0d_word_msb", i), word_m,        vecs[i].exp_wm);
      chk($sformatf("v%0d_count", i),   {30'd0, cnt_l}, {30'd0, vecs[i].exp_cnt});
    end

    // Test 1: async reset while two bytes are held
    step(1'b1, 8'hE1, 1'b0, 1'b1); post_edge();
    step(1'b1, 8'hE2, 1'b0, 1'b1); post_edge();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("midword_count", {30'd0, cnt_l}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", {30'd0, cnt_l}, 32'd0);
    chk("async_rst_word",  word_l, 32'h0);
    chk("async_rst_valid", {31'd0, wv_l}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    post_edge();

    // Test 4: backpressure with a byte waiting
    step(1'b1, 8'hDD, 1'b0, 1'b0); post_edge();
    step(1'b1, 8'hCC, 1'b0, 1'b0); post_edge();
    step(1'b1, 8'hBB, 1'b0, 1'b0); post_edge();
    step(1'b1, 8'hAA, 1'b0, 1'b0); post_edge();
    chk("bp_word", word_l, 32'hAABBCCDD);
    chk("bp_valid", {31'd0, wv_l}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'h55, 1'b0, 1'b0);
      chk($sformatf("bp_hold%0d_ready", k), {31'd0, ready_l}, 32'd0);
      post_edge();
      chk($sformatf("bp_hold%0d_valid", k), {31'd0, wv_l}, 32'd1);
      chk($sformatf("bp_hold%0d_word", k),  word_l, 32'hAABBCCDD);
      chk($sformatf("bp_hold%0d_count", k), {30'd0, cnt_l}, 32'd0);
    end
    step(1'b1, 8'h55, 1'b0, 1'b1);
    chk("bp_release_ready", {31'd0, ready_l}, 32'd1);
    post_edge();
    chk("bp_release_valid", {31'd0, wv_l}, 32'd0);
    chk("bp_release_count", {30'd0, cnt_l}, 32'd1);
    chk("bp_release_word",  word_l, 32'hAABBCCDD);
    step(1'b1, 8'h66, 1'b0, 1'b1); post_edge();
    step(1'b1, 8'h77, 1'b0, 1'b1); post_edge();
    step(1'b1, 8'h88, 1'b0, 1'b1); post_edge();
    chk("bp_next_word",  word_l, 32'h88776655);
    chk("bp_next_valid", {31'd0, wv_l}, 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1); post_edge();

    // Flush while FULL leaves the held word alone
    step(1'b1, 8'h10, 1'b0, 1'b0); post_edge();
    step(1'b1, 8'h20, 1'b0, 1'b0); post_edge();
    step(1'b1, 8'h30, 1'b0, 1'b0); post_edge();
    step(1'b1, 8'h40, 1'b0, 1'b0); post_edge();
    step(1'b0, 8'h00, 1'b1, 1'b0); post_edge();
    chk("full_flush_valid", {31'd0, wv_l}, 32'd1);
    chk("full_flush_word",  word_l, 32'h40302010);
    step(1'b0, 8'h00, 1'b1, 1'b1); post_edge();
    chk("full_flush_handoff", {31'd0, wv_l}, 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1); post_edge();

    // Test 6: gapped stream of 8 words through the downstream register
    for (int k = 0; k < 32; k++) sbytes[k] = 8'($urandom_range(0, 255));
    for (int w = 0; w < 8; w++)
      exp_words[w] = {sbytes[4*w+3], sbytes[4*w+2], sbytes[4*w+1], sbytes[4*w]};
    pend   = 1'b0;
    got    = 0;
    mon_en = 1'b1;
    idx    = 0;
    cyc    = 0;
    while (got < 8 && cyc < 2000) begin
      step((idx < 32) && ($urandom_range(0, 2) != 0),
           (idx < 32) ? sbytes[idx] : 8'h00, 1'b0, ($urandom_range(0, 1) == 1));
      if (byte_valid && ready_l) idx++;
      post_edge();
      cyc++;
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    mon_en = 1'b0;
    chk("stream_words_seen", got, 32'd8);
    chk("stream_bytes_sent", idx, 32'd32);
    chk("stream_final_count", {30'd0, cnt_l}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_byte_word_packer

`default_nettype wire
